// File: rtl/conv.sv
// Signed 8+8 -> 9-bit registered adder. Latency 1 clock, or 2 with CONV_INREG_EN.
// No handshake and no backpressure: one result accepted and produced every clock.
module conv (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] CONV_iData0,
  input  logic [7:0] CONV_iData1,
  output logic [8:0] CONV_oData
);

  logic [7:0] opa;
  logic [7:0] opb;
  logic [8:0] sum_d;
  logic [8:0] sum_q;

`ifdef CONV_INREG_EN
  logic [7:0] a_d;
  logic [7:0] a_q;
  logic [7:0] b_d;
  logic [7:0] b_q;

  always_comb begin
    a_d = CONV_iData0;
    b_d = CONV_iData1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= 8'h00;
      b_q <= 8'h00;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign opa = a_q;
  assign opb = b_q;
`else
  assign opa = CONV_iData0;
  assign opb = CONV_iData1;
`endif

  // Sign-extend to 9 bits so the sum is exact across the full operand range.
  always_comb begin
    sum_d = {opa[7], opa} + {opb[7], opb};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= 9'h000;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign CONV_oData = sum_q;

endmodule

// File: tb/tb_conv.sv
// Bench for conv: arithmetic model over sampled-input history plus literal checks.
module tb_conv;

`ifdef CONV_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [8:0] out_d;

  int n_pass;
  int n_total;
  int cyc;

  bit         hist_rst [int];
  int         hist_sum [int];
  logic [8:0] lit_exp  [int];

  conv dut (
    .clk         (clk),
    .reset       (reset),
    .CONV_iData0 (in_a),
    .CONV_iData1 (in_b),
    .CONV_oData  (out_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Output after edge n: zero if reset was seen in the last LAT edges,
  // otherwise the exact signed sum of the inputs sampled LAT-1 edges earlier.
  function automatic logic [8:0] model_out(input int n);
    int src;
    logic [8:0] r;
    src = n - LAT + 1;
    if (src < 1) return 9'h000;
    for (int k = src; k <= n; k++) begin
      if (hist_rst[k]) return 9'h000;
    end
    r = 9'(hist_sum[src]);
    return r;
  endfunction

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      hist_rst[cyc] = (reset !== 1'b0);
      hist_sum[cyc] = int'($signed(in_a)) + int'($signed(in_b));
      #1;
      check("model", out_d, model_out(cyc));
      if (lit_exp.exists(cyc)) check("literal", out_d, lit_exp[cyc]);
    end
  end

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic r,
                      input bit has_lit, input logic [8:0] lit);
    @(negedge clk);
    in_a  = a;
    in_b  = b;
    reset = r;
    if (has_lit) lit_exp[cyc + LAT] = lit;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    in_a    = 8'hxx;
    in_b    = 8'hxx;

    repeat (256) begin
      @(negedge clk);
      reset = 1'b1;
      in_a  = 8'hxx;
      in_b  = 8'hxx;
      lit_exp[cyc + 1] = 9'h000;
    end

    repeat (6) step(8'd3, 8'hFE, 1'b0, 1'b1, 9'h001);

    step(8'd127, 8'd127, 1'b0, 1'b1, 9'h0FE);
    step(8'h80,  8'h80,  1'b0, 1'b1, 9'h100);
    step(8'd127, 8'h80,  1'b0, 1'b1, 9'h1FF);
    step(8'h80,  8'd127, 1'b0, 1'b1, 9'h1FF);
    step(8'hFF,  8'hFF,  1'b0, 1'b1, 9'h1FE);

    step(8'd0, 8'hFF, 1'b0, 1'b1, 9'h1FF);
    step(8'd1, 8'hFF, 1'b0, 1'b1, 9'h000);
    step(8'd2, 8'hFF, 1'b0, 1'b1, 9'h001);
    step(8'd3, 8'hFF, 1'b0, 1'b1, 9'h002);

    // One-cycle reset mid-stream: in-flight and own sample both discarded.
    @(negedge clk);
    in_a  = 8'd50;
    in_b  = 8'd60;
    reset = 1'b1;
    lit_exp[cyc + 1]   = 9'h000;
    lit_exp[cyc + LAT] = 9'h000;

    step(8'd10, 8'hFD, 1'b0, 1'b1, 9'h007);
    step(8'hC0, 8'hC0, 1'b0, 1'b1, 9'h180);
    step(8'd100, 8'hCE, 1'b0, 1'b1, 9'h032);

    repeat (LAT + 2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
